// File: rtl/anim_frame_sequencer.sv
// anim_frame_sequencer: LED animation playback sequencer with digit scan.
// Broadcasts a 5-bit frame index to the per-digit decoders and time-multiplexes
// their active-low segment outputs onto one shared bus.
// Optional feature macro: ANIM_PINGPONG_EN (bounce between 0 and LAST_FRAME).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped, frame parked at 0, prescaler cleared
//   RUN   | playing; prescaler runs unless paused, frame advances on tick
//   DONE  | playback ended naturally, last frame held until start/stop
module anim_frame_sequencer #(
  parameter int TICK_DIV   = 100000,
  parameter int SCAN_DIV   = 1000,
  parameter int DIGITS     = 4,
  parameter int LAST_FRAME = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
  input  logic [DIGITS*7-1:0]   seg_in,
  output logic [4:0]            frame,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TICK_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [4:0]    LAST      = 5'(LAST_FRAME);
  localparam logic [2:0]    IDX_MAX   = 3'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    frame_q, frame_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_d;
  logic          tick;

`ifdef ANIM_PINGPONG_EN
  // 1 = counting up, 0 = counting down
  logic          dir_up_q, dir_up_d;
`endif

  logic [SW-1:0] scan_cnt_q;
  logic [2:0]    scan_idx_q;
  logic          scan_wrap;

  assign tick  = (state_q == RUN) && !pause && (presc_q == TICK_MAX);
  assign frame = frame_q;

  // Playback state register; busy and done are registered alongside state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= 5'd0;
      presc_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_up_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      presc_q  <= presc_d;
      busy     <= (state_d == RUN);
      done     <= done_d;
`ifdef ANIM_PINGPONG_EN
      dir_up_q <= dir_up_d;
`endif
    end
  end

  // Next-state logic: prescaler, frame advance, start/stop overrides.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
`ifdef ANIM_PINGPONG_EN
    dir_up_d = dir_up_q;
`endif

    case (state_q)
      RUN: begin
        if (!pause) begin
          presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
`ifdef ANIM_PINGPONG_EN
          if (dir_up_q) begin
            if (frame_q < LAST) begin
              frame_d = frame_q + 5'd1;
            end else begin
              // Bounce off the top regardless of loop_en.
              dir_up_d = 1'b0;
              frame_d  = LAST - 5'd1;
            end
          end else begin
            if (frame_q != 5'd0) begin
              frame_d = frame_q - 5'd1;
            end else if (loop_en) begin
              dir_up_d = 1'b1;
              frame_d  = 5'd1;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
`else
          if (frame_q < LAST) begin
            frame_d = frame_q + 5'd1;
          end else if (loop_en) begin
            frame_d = 5'd0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end
      default: begin
        presc_d = '0;
      end
    endcase

    if (start) begin
      state_d  = RUN;
      frame_d  = 5'd0;
      presc_d  = '0;
      done_d   = 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_up_d = 1'b1;
`endif
    end

    // stop has priority over a simultaneous start.
    if (stop) begin
      state_d  = IDLE;
      frame_d  = 5'd0;
      presc_d  = '0;
      done_d   = 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_up_d = 1'b1;
`endif
    end
  end

  assign scan_wrap = (scan_cnt_q == SCAN_MAX);

  // Free-running digit scan; the slot change cycle is blanked to avoid ghosting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 3'd0;
      dig        <= '1;
      seg        <= 7'h7F;
    end else begin
      if (scan_wrap) begin
        scan_cnt_q <= '0;
        scan_idx_q <= (scan_idx_q == IDX_MAX) ? 3'd0 : scan_idx_q + 3'd1;
        dig        <= '1;
        seg        <= 7'h7F;
      end else begin
        scan_cnt_q <= scan_cnt_q + SW'(1);
        dig        <= ~(DIGITS'(1) << scan_idx_q);
        seg        <= seg_in[7*scan_idx_q +: 7];
      end
    end
  end

endmodule
